cla_adder_pipe: RTL and testbench
=================================

Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's 4-bit lookahead adder.
- The operand is split into GRP-bit lookahead groups. Each pipeline stage resolves one group and registers the carry into the next stage.
- Throughput is one operation per cycle, with a valid/ready handshake on both sides.
- Sits between the ALU operand registers and the result writeback in the datapath experiments.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GRP, minimum GRP.
- GRP, 4, bits per lookahead group.
- NG, WIDTH/GRP, number of groups = pipeline depth (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- C0  in  1  carry-in; ignored when sub=1.
- sub  in  1  1 = A-B (B inverted, carry-in forced 1); 0 = A+B+C0.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- F  out  WIDTH  sum/difference.
- C4  out  1  carry out of MSB (for sub: 1 = no borrow).
- V  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- Z  out  1  F == 0.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0:
  - all stage valid bits clear; out_valid=0.
  - F, C4, V, Z = 0.
  - in-flight beats are discarded, and reset mid-operation emits no partial result.
  - in_ready=1 from the first cycle after reset.
- Operand preparation at stage 0 capture:
  - Bm = sub ? ~B : B.
  - cin = sub ? 1 : C0.
- Stage k (0..NG-1) computes group k:
  - P = A_k ^ Bm_k, G = A_k & Bm_k.
  - Ripple-free lookahead: c[i+1] = G[i] | P[i]&c[i], expanded per group.
  - Sum bits = P ^ c.
- Stage k registers:
  - the sum bits of groups 0..k (deskewed, carried forward);
  - the group carry-out;
  - the remaining operand groups k+1..NG-1 (skewed).
- Final stage also registers:
  - C4 = carry out of group NG-1;
  - V = c[WIDTH-1] ^ c[WIDTH];
  - Z = ~|F.
- Latency: NG cycles from accepted input (in_valid & in_ready) to out_valid. Results emerge in order, one per cycle when unstalled.
- Flow control, global enable: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational.
  - When adv=0, every stage register, including outputs, holds.
  - When adv=1, all stages shift. A stage with no incoming beat loads valid=0 (bubble).
- Output stability: while out_valid=1 and out_ready=0, F/C4/V/Z/out_valid are stable.
- Simultaneous accept and emit in the same cycle is legal. A full pipeline with out_ready held at 1 sustains 1 beat/cycle.
- in_valid=0 with adv=1 injects a bubble; data registers may hold don't-care when valid=0, but outputs are unchanged while out_valid=0.
- Wrap-around:
  - unsigned overflow is reported only via C4;
  - F is modulo 2^WIDTH;
  - no saturation.
- Case NG=1: degenerates to a single-stage registered adder with latency 1.

Decomposition:
- Package cla_pkg:
  - the function computing one GRP-bit lookahead (P, G, carries, sum);
  - the localparam formula NG = WIDTH/GRP;
  - an elaboration check that WIDTH % GRP == 0.
- Sub-module cla_group:
  - combinational, GRP-bit, ports A, B, cin, S, cout;
  - one instance per stage via generate.
- Pipeline registers and handshake live in cla_adder_pipe.

Test Plan (WIDTH=16, GRP=4, latency 4):
1. Reset, then A=16'h1234, B=16'h4321, C0=0, sub=0, out_ready=1 → exactly 4 cycles later: out_valid=1, F=16'h5555, C4=0, V=0, Z=0.
2. A=16'hFFFF, B=16'h0001, C0=0, sub=0 → F=0, C4=1, Z=1, V=0. Then A=16'h7FFF, B=1 → F=16'h8000, V=1, C4=0.
3. sub=1, A=16'h0005, B=16'h0007, C0=1 (ignored) → F=16'hFFFE, C4=0 (borrow), V=0. Then A=16'h8000, B=1 → F=16'h7FFF, V=1, C4=1.
4. Back-to-back beats i=0..9 with A=i, B=i*3, out_ready=1 → 10 consecutive out_valid cycles, F=4i in order, in_ready never low.
5. Backpressure: stream 6 beats while out_ready is held 0 from cycle 5 → in_ready falls the cycle out_valid rises with out_ready=0; outputs are held stable; on release, all 6 results arrive in order with none lost or duplicated.
6. Assert rst_n=0 for one cycle with 3 beats in flight → out_valid=0, F=0, C4=V=Z=0 next cycle; the in-flight beats never appear; a new beat issued after reset completes with 4-cycle latency.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared lookahead helpers and sizing for the pipelined CLA adder
package cla_pkg;

  localparam int GRP_MAX = 32;

  typedef struct packed {
    logic [GRP_MAX-1:0] s;
    logic               cout;
  } grp_res_t;

  function automatic int calc_ng(input int width, input int grp);
    return width / grp;
  endfunction

  function automatic bit width_ok(input int width, input int grp);
    return (grp > 0) && (grp <= GRP_MAX) && (width >= grp) && ((width % grp) == 0);
  endfunction

  // Each carry is a flat sum of products over G/P terms and cin,
  // so no carry depends on a previously computed carry.
  function automatic grp_res_t cla_lookahead(input logic [GRP_MAX-1:0] a,
                                             input logic [GRP_MAX-1:0] b,
                                             input logic               cin,
                                             input int                 grp);
    grp_res_t             res;
    logic [GRP_MAX-1:0]   p;
    logic [GRP_MAX-1:0]   g;
    logic [GRP_MAX:0]     c;
    logic                 pp;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    pp   = 1'b0;
    for (int i = 0; i < GRP_MAX; i++) begin
      if (i < grp) begin
        c[i+1] = g[i];
        pp     = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          c[i+1] = c[i+1] | (pp & g[j]);
          pp     = pp & p[j];
        end
        c[i+1] = c[i+1] | (pp & cin);
      end
    end
    res.s    = p ^ c[GRP_MAX-1:0];
    res.cout = c[grp];
    return res;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// rtl/cla_adder_pipe_if.sv - operand/result handshake bundle for cla_adder_pipe
interface cla_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C0;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             C4;
  logic             V;
  logic             Z;

  modport master (
    output in_valid, A, B, C0, sub, out_ready,
    input  in_ready, out_valid, F, C4, V, Z
  );

  modport slave (
    input  in_valid, A, B, C0, sub, out_ready,
    output in_ready, out_valid, F, C4, V, Z
  );
endinterface

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GRP-bit carry-lookahead group
module cla_group
  import cla_pkg::*;
#(
  parameter int GRP = 4
) (
  input  logic [GRP-1:0] A,
  input  logic [GRP-1:0] B,
  input  logic           cin,
  output logic [GRP-1:0] S,
  output logic           cout
);

  grp_res_t res;

  always_comb begin
    res  = cla_lookahead(GRP_MAX'(A), GRP_MAX'(B), cin, GRP);
    S    = res.s[GRP-1:0];
    cout = res.cout;
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-lookahead adder/subtractor, one group per stage
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input logic              clk,
  input logic              rst_n,
  cla_adder_pipe_if.slave  bus
);

  localparam int NG = calc_ng(WIDTH, GRP);
  localparam logic [WIDTH-1:0] GRP_MASK = WIDTH'({GRP{1'b1}});

  if (!width_ok(WIDTH, GRP)) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a non-zero multiple of GRP");
  end

  logic             adv;
  logic [WIDTH-1:0] bm;
  logic             cin;
  logic             c_msb;

  logic             valid_q [NG];
  logic [WIDTH-1:0] sum_q   [NG];
  logic [WIDTH-1:0] a_q     [NG];
  logic [WIDTH-1:0] bm_q    [NG];
  logic             c_q     [NG];
  logic             v_q;
  logic             z_q;

  logic             stg_v    [NG];
  logic [WIDTH-1:0] stg_a    [NG];
  logic [WIDTH-1:0] stg_bm   [NG];
  logic [WIDTH-1:0] stg_s    [NG];
  logic             stg_c    [NG];
  logic [WIDTH-1:0] next_sum [NG];
  logic [GRP-1:0]   grp_s    [NG];
  logic             grp_cout [NG];

  // One global enable: the whole pipe freezes only when the result is stuck.
  assign adv = ~valid_q[NG-1] | bus.out_ready;
  assign bm  = bus.sub ? ~bus.B : bus.B;
  assign cin = bus.sub | bus.C0;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stg_v[k]  = bus.in_valid;
      assign stg_a[k]  = bus.A;
      assign stg_bm[k] = bm;
      assign stg_c[k]  = cin;
      assign stg_s[k]  = '0;
    end else begin : g_next
      assign stg_v[k]  = valid_q[k-1];
      assign stg_a[k]  = a_q[k-1];
      assign stg_bm[k] = bm_q[k-1];
      assign stg_c[k]  = c_q[k-1];
      assign stg_s[k]  = sum_q[k-1];
    end

    cla_group #(.GRP(GRP)) u_group (
      .A    (stg_a[k][k*GRP +: GRP]),
      .B    (stg_bm[k][k*GRP +: GRP]),
      .cin  (stg_c[k]),
      .S    (grp_s[k]),
      .cout (grp_cout[k])
    );

    assign next_sum[k] = (stg_s[k] & ~(GRP_MASK << (k*GRP))) |
                         (WIDTH'(grp_s[k]) << (k*GRP));
  end

  // Carry into the MSB recovered from its sum bit: c = S ^ P.
  assign c_msb = grp_s[NG-1][GRP-1] ^ stg_a[NG-1][WIDTH-1] ^ stg_bm[NG-1][WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NG; k++) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        bm_q[k]    <= '0;
        c_q[k]     <= 1'b0;
      end
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NG; k++) begin
        valid_q[k] <= stg_v[k];
        if (stg_v[k]) begin
          sum_q[k] <= next_sum[k];
          a_q[k]   <= stg_a[k];
          bm_q[k]  <= stg_bm[k];
          c_q[k]   <= grp_cout[k];
        end
      end
      if (stg_v[NG-1]) begin
        v_q <= c_msb ^ grp_cout[NG-1];
        z_q <= ~|next_sum[NG-1];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[NG-1];
  assign bus.F         = sum_q[NG-1];
  assign bus.C4        = c_q[NG-1];
  assign bus.V         = v_q;
  assign bus.Z         = z_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - directed self-checking bench for cla_adder_pipe
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  cla_adder_pipe_if #(.WIDTH(16)) bus ();

  cla_adder_pipe #(.WIDTH(16), .GRP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic c0, input logic s, output int early);
    bus.A = a; bus.B = b; bus.C0 = c0; bus.sub = s; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.out_valid) early++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.C0 = 1'b0; bus.sub = 1'b0;
    step(); step();
    n_checks++;
    if ({bus.out_valid, bus.F, bus.C4, bus.V, bus.Z} !== 20'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {bus.out_valid, bus.F, bus.C4, bus.V, bus.Z});
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_basic();
    int early;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, early);
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL basic_latency: early valids %0d want 0", early); end
    n_checks++;
    if ({bus.out_valid, bus.F, bus.C4, bus.V, bus.Z} !== {1'b1, 16'h5555, 3'b000}) begin
      n_fail++; $display("FAIL basic_add: got %h want %h", {bus.out_valid, bus.F, bus.C4, bus.V, bus.Z}, {1'b1, 16'h5555, 3'b000});
    end
  endtask

  task automatic test_wrap();
    int early;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, early);
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL wrap_latency: early valids %0d want 0", early); end
    n_checks++;
    if ({bus.out_valid, bus.F, bus.C4, bus.V, bus.Z} !== {1'b1, 16'h0000, 3'b101}) begin
      n_fail++; $display("FAIL wrap_zero: got %h want %h", {bus.out_valid, bus.F, bus.C4, bus.V, bus.Z}, {1'b1, 16'h0000, 3'b101});
    end
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, early);
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL ovf_latency: early valids %0d want 0", early); end
    n_checks++;
    if ({bus.out_valid, bus.F, bus.C4, bus.V, bus.Z} !== {1'b1, 16'h8000, 3'b010}) begin
      n_fail++; $display("FAIL ovf_add: got %h want %h", {bus.out_valid, bus.F, bus.C4, bus.V, bus.Z}, {1'b1, 16'h8000, 3'b010});
    end
  endtask

  task automatic test_sub();
    int early;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, early);
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL sub_latency: early valids %0d want 0", early); end
    n_checks++;
    if ({bus.out_valid, bus.F, bus.C4, bus.V, bus.Z} !== {1'b1, 16'hFFFE, 3'b000}) begin
      n_fail++; $display("FAIL sub_borrow: got %h want %h", {bus.out_valid, bus.F, bus.C4, bus.V, bus.Z}, {1'b1, 16'hFFFE, 3'b000});
    end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, early);
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL sub_ovf_latency: early valids %0d want 0", early); end
    n_checks++;
    if ({bus.out_valid, bus.F, bus.C4, bus.V, bus.Z} !== {1'b1, 16'h7FFF, 3'b110}) begin
      n_fail++; $display("FAIL sub_ovf: got %h want %h", {bus.out_valid, bus.F, bus.C4, bus.V, bus.Z}, {1'b1, 16'h7FFF, 3'b110});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got[$];
    int first = -1;
    int last = -1;
    int ready_low = 0;
    step();
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (bus.in_ready !== 1'b1) ready_low++;
      if (bus.out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        got.push_back(bus.F);
      end
      if (cyc < 10) begin
        bus.A = 16'(cyc); bus.B = 16'(cyc * 3); bus.C0 = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
    end
    n_checks++;
    if (ready_low !== 0) begin n_fail++; $display("FAIL b2b_in_ready: low cycles %0d want 0", ready_low); end
    n_checks++;
    if (got.size() !== 10) begin n_fail++; $display("FAIL b2b_count: got %0d want 10", got.size()); end
    n_checks++;
    if (first !== 4 || last !== 13) begin
      n_fail++; $display("FAIL b2b_window: got first %0d last %0d want 4 13", first, last);
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_checks++;
      if (got[i] !== 16'(4 * i)) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got[i], 16'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    logic [15:0] hold_f = '0;
    int idx = 0;
    int unstable = 0;
    bit acc;
    bus.out_ready = 1'b1;
    step();
    for (int cyc = 0; cyc < 25; cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc < 10);
      #1;
      if (cyc == 4) begin
        hold_f = bus.F;
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
          n_fail++; $display("FAIL bp_stall_onset: valid/ready %b want 10", {bus.out_valid, bus.in_ready});
        end
      end
      if (cyc >= 5 && cyc < 10 && {bus.out_valid, bus.in_ready, bus.F} !== {2'b10, hold_f}) unstable++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.F);
      if (idx < 6) begin
        bus.A = 16'(idx * 16'h0101); bus.B = 16'hF0F0; bus.C0 = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = (idx < 6) && bus.in_ready;
      step();
      if (acc) idx++;
    end
    n_checks++;
    if (unstable !== 0) begin n_fail++; $display("FAIL bp_hold: unstable cycles %0d want 0", unstable); end
    n_checks++;
    if (got.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_checks++;
      if (got[i] !== 16'hF0F0 + 16'(i * 16'h0101)) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], 16'hF0F0 + 16'(i * 16'h0101));
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int early;
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.A = 16'h0100 + 16'(i); bus.B = 16'h0011; bus.C0 = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
      step();
    end
    rst_n = 1'b0; bus.in_valid = 1'b0;
    step();
    n_checks++;
    if ({bus.out_valid, bus.F, bus.C4, bus.V, bus.Z} !== 20'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h want 0", {bus.out_valid, bus.F, bus.C4, bus.V, bus.Z});
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midreset_ghost: stale valids %0d want 0", seen); end
    run_op(16'h0002, 16'h0003, 1'b0, 1'b0, early);
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL midreset_latency: early valids %0d want 0", early); end
    n_checks++;
    if ({bus.out_valid, bus.F, bus.C4, bus.V, bus.Z} !== {1'b1, 16'h0005, 3'b000}) begin
      n_fail++; $display("FAIL midreset_result: got %h want %h", {bus.out_valid, bus.F, bus.C4, bus.V, bus.Z}, {1'b1, 16'h0005, 3'b000});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
